// File: rtl/din_sched_pkg.sv
// rtl/din_sched_pkg.sv - shared types and default sizes for the DinA round-robin scheduler
package din_sched_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_DW          = 4;
  localparam int DEF_HOLD_CYCLES = 4;

endpackage

// File: rtl/din_rr_scheduler_rr_pick.sv
// rtl/din_rr_scheduler_rr_pick.sv - combinational round-robin picker
// Searches from last+1 upward, wrapping modulo N_REQ, for the first set request.
module rr_pick
  import din_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic             any,
  output logic [IDW-1:0]   win,
  output logic [N_REQ-1:0] onehot
);

  logic [IDW-1:0] pos;

  always_comb begin
    any = 1'b0;
    win = '0;
    pos = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      // Modulo on the full int keeps the wrap correct for non-power-of-2 N_REQ.
      pos = IDW'((int'(last) + k) % N_REQ);
      if (!any && req[pos]) begin
        any = 1'b1;
        win = pos;
      end
    end
  end

  assign onehot = any ? (N_REQ'(1) << win) : '0;

endmodule

// File: rtl/din_rr_scheduler.sv
// rtl/din_rr_scheduler.sv - round-robin sharing of the datapath DinA input
// Grants one requester at a time and holds its nibble on DinA for HOLD_CYCLES cycles.
module din_rr_scheduler
  import din_sched_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int DW          = DEF_DW,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int IDW         = $clog2(N_REQ)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]  gnt,
  output logic [IDW-1:0]    grant_id,
  output logic [DW-1:0]     DinA,
  output logic              din_valid,
  output logic              busy
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  last;

  logic            any;
  logic [IDW-1:0]  win;
  logic [N_REQ-1:0] win_onehot;
  logic            arb;
  logic [DW-1:0]   data_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = req_data[i*DW +: DW];
    end
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req    (req),
    .last   (last),
    .any    (any),
    .win    (win),
    .onehot (win_onehot)
  );

  // The counter is 0 in IDLE too, so one test covers both arbitration points.
  assign arb  = en && any && (cnt == '0);
  assign busy = (state == S_HOLD);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last      <= IDW'(N_REQ - 1);
      gnt       <= '0;
      grant_id  <= '0;
      DinA      <= '0;
      din_valid <= 1'b0;
    end else begin
      gnt <= '0;
      if (arb) begin
        state     <= S_HOLD;
        cnt       <= CW'(HOLD_CYCLES - 1);
        last      <= win;
        gnt       <= win_onehot;
        grant_id  <= win;
        DinA      <= data_arr[win];
        din_valid <= 1'b1;
      end else if (state == S_HOLD) begin
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end else begin
          state     <= S_IDLE;
          din_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_din_rr_scheduler.sv
// tb/tb_din_rr_scheduler.sv - bench for din_rr_scheduler with HOLD_CYCLES=4 and =1 instances
module tb_din_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_a, req_b;
  logic [15:0] data_a, data_b;

  logic [3:0]  gnt_a, gnt_b;
  logic [1:0]  id_a, id_b;
  logic [3:0]  dina_a, dina_b;
  logic        valid_a, valid_b, busy_a, busy_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  din_rr_scheduler #(.N_REQ(4), .DW(4), .HOLD_CYCLES(4)) dut (
    .clock(clk), .rst(rst), .en(en), .req(req_a), .req_data(data_a),
    .gnt(gnt_a), .grant_id(id_a), .DinA(dina_a), .din_valid(valid_a), .busy(busy_a)
  );

  din_rr_scheduler #(.N_REQ(4), .DW(4), .HOLD_CYCLES(1)) dut1 (
    .clock(clk), .rst(rst), .en(en), .req(req_b), .req_data(data_b),
    .gnt(gnt_b), .grant_id(id_b), .DinA(dina_b), .din_valid(valid_b), .busy(busy_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining hold cycles per instance, valid while nonzero.
  int         m_rem  [2];
  int         m_last [2];
  int         m_id   [2];
  logic [3:0] m_gnt  [2];
  logic [3:0] m_dina [2];

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_rem[i]  <= 0;
        m_last[i] <= 3;
        m_id[i]   <= 0;
        m_gnt[i]  <= 4'b0;
        m_dina[i] <= 4'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0]  r;
        logic [15:0] d;
        int          h;
        int          w;
        r = (i == 0) ? req_a : req_b;
        d = (i == 0) ? data_a : data_b;
        h = (i == 0) ? 4 : 1;
        if (en && r != 4'b0 && m_rem[i] <= 1) begin
          w = pick(r, m_last[i]);
          m_gnt[i]  <= 4'(1 << w);
          m_id[i]   <= w;
          m_last[i] <= w;
          m_dina[i] <= d[w*4 +: 4];
          m_rem[i]  <= h;
        end else begin
          m_gnt[i] <= 4'b0;
          if (m_rem[i] > 0) m_rem[i] <= m_rem[i] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("gnt_a",   int'(gnt_a),   int'(m_gnt[0]));
    check("id_a",    int'(id_a),    m_id[0]);
    check("dina_a",  int'(dina_a),  int'(m_dina[0]));
    check("valid_a", int'(valid_a), int'(m_rem[0] > 0));
    check("busy_a",  int'(busy_a),  int'(m_rem[0] > 0));
    check("gnt_b",   int'(gnt_b),   int'(m_gnt[1]));
    check("id_b",    int'(id_b),    m_id[1]);
    check("dina_b",  int'(dina_b),  int'(m_dina[1]));
    check("valid_b", int'(valid_b), int'(m_rem[1] > 0));
    check("busy_b",  int'(busy_b),  int'(m_rem[1] > 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    req_a = '0; req_b = '0; data_a = '0; data_b = '0;
    tick();
    tick();
    check("rst_gnt",   int'(gnt_a),   0);
    check("rst_id",    int'(id_a),    0);
    check("rst_dina",  int'(dina_a),  0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_busy",  int'(busy_a),  0);
    rst = 1'b0;

    // single request from requester 2
    en = 1'b1; req_a = 4'b0100; data_a = 16'h0A00;
    tick();
    check("single_gnt",   int'(gnt_a),   4'b0100);
    check("single_id",    int'(id_a),    2);
    check("single_dina",  int'(dina_a),  4'hA);
    check("single_valid", int'(valid_a), 1);
    req_a = 4'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("single_hold_valid", int'(valid_a), 1);
      check("single_hold_gnt",   int'(gnt_a),   0);
      check("single_hold_dina",  int'(dina_a),  4'hA);
    end
    tick();
    check("single_end_valid", int'(valid_a), 0);
    check("single_end_dina",  int'(dina_a),  4'hA);

    // fairness: 0 first, then 1001 goes to 3
    do_reset();
    req_a = 4'b0001; data_a = 16'h4321;
    tick();
    check("fair_first", int'(gnt_a), 4'b0001);
    req_a = 4'b1001;
    for (int c = 0; c < 3; c++) tick();
    check("fair_b2b_valid", int'(valid_a), 1);
    tick();
    check("fair_second", int'(gnt_a), 4'b1000);
    check("fair_second_id", int'(id_a), 3);
    check("fair_second_dina", int'(dina_a), 4'h4);
    req_a = 4'b0001;
    for (int c = 0; c < 4; c++) tick();
    check("fair_third", int'(gnt_a), 4'b0001);
    req_a = 4'b0;

    // all four continuously: 1,2,3,4,... each 4 cycles
    do_reset();
    req_a = 4'b1111; data_a = 16'h4321;
    for (int c = 0; c < 16; c++) begin
      tick();
      check("rr_dina",  int'(dina_a),  (c / 4) % 4 + 1);
      check("rr_valid", int'(valid_a), 1);
    end

    // en dropped mid-hold
    do_reset();
    req_a = 4'b1111;
    tick();
    check("en_gnt", int'(gnt_a), 4'b0001);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("en_hold_valid", int'(valid_a), 1);
    end
    tick();
    check("en_idle_valid", int'(valid_a), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("en_idle_gnt", int'(gnt_a), 0);
    end
    en = 1'b1;
    tick();
    check("en_resume_gnt", int'(gnt_a), 4'b0010);
    check("en_resume_id",  int'(id_a),  1);

    // async reset two cycles into a hold
    do_reset();
    req_a = 4'b1111;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_dina",  int'(dina_a),  0);
    check("arst_valid", int'(valid_a), 0);
    check("arst_gnt",   int'(gnt_a),   0);
    check("arst_busy",  int'(busy_a),  0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_regrant", int'(gnt_a), 4'b0001);
    req_a = 4'b0;

    // HOLD_CYCLES=1 alternation
    do_reset();
    req_b = 4'b0011; data_b = 16'h00C5;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("h1_gnt",   int'(gnt_b),   (c % 2 == 0) ? 4'b0001 : 4'b0010);
      check("h1_dina",  int'(dina_b),  (c % 2 == 0) ? 4'h5 : 4'hC);
      check("h1_valid", int'(valid_b), 1);
    end
    req_b = 4'b0;

    // randomized traffic, model compare only
    for (int c = 0; c < 600; c++) begin
      en     = ($urandom_range(0, 9) != 0);
      req_a  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      req_b  = 4'($urandom_range(0, 15));
      data_a = 16'($urandom);
      data_b = 16'($urandom);
      rst    = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
